csa: RTL and testbench



---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_core.sv | 67 ++++++
 rtl/csa_fa.sv | 16 +
 rtl/csa.sv | 48 ++++
 tb/tb_csa.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-select adder slice.
package csa_pkg;

  // Legal operand widths for the adder.
  localparam int unsigned CSA_N_MIN = 1;
  localparam int unsigned CSA_N_MAX = 32;

  // Width of the low half when a stage of width n is split (floor of n/2).
  function automatic int unsigned csa_lo_width(input int unsigned n);
    return n / 2;
  endfunction

  // Width of the high half: whatever the low half does not take.
  function automatic int unsigned csa_hi_width(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/csa_core.sv
// Purely combinational carry-select adder of width W, built recursively.
// A width-1 stage is a single full adder. Wider stages split into a low half
// (fed by the real carry-in) and two speculative copies of the high half
// (carry-in 0 and carry-in 1); the low half's carry-out picks the high copy.
module csa_core
  import csa_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);

  if (W == 1) begin : g_leaf
    fa u_fa (
      .a_i  (a_i[0]),
      .b_i  (b_i[0]),
      .ci_i (ci_i),
      .s_o  (sum_o[0]),
      .co_o (co_o)
    );
  end else begin : g_split
    localparam int unsigned L = csa_lo_width(W);
    localparam int unsigned H = csa_hi_width(W);

    logic [L-1:0] sum_lo;
    logic         c_lo;
    logic [H-1:0] sum_hi0;
    logic [H-1:0] sum_hi1;
    logic         co_hi0;
    logic         co_hi1;

    csa_core #(.W(L)) u_lo (
      .a_i   (a_i[L-1:0]),
      .b_i   (b_i[L-1:0]),
      .ci_i  (ci_i),
      .sum_o (sum_lo),
      .co_o  (c_lo)
    );

    csa_core #(.W(H)) u_hi0 (
      .a_i   (a_i[W-1:L]),
      .b_i   (b_i[W-1:L]),
      .ci_i  (1'b0),
      .sum_o (sum_hi0),
      .co_o  (co_hi0)
    );

    csa_core #(.W(H)) u_hi1 (
      .a_i   (a_i[W-1:L]),
      .b_i   (b_i[W-1:L]),
      .ci_i  (1'b1),
      .sum_o (sum_hi1),
      .co_o  (co_hi1)
    );

    // Low-half carry selects which speculative high half is the real one.
    always_comb begin
      sum_o = {(c_lo ? sum_hi1 : sum_hi0), sum_lo};
      co_o  = c_lo ? co_hi1 : co_hi0;
    end
  end

endmodule

// File: rtl/csa_fa.sv
// 1-bit full adder: the leaf cell of the carry-select recursion.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule

// File: rtl/csa.sv
// N-bit carry-select adder with combinational sum/carry and a registered
// copy of both for pipelined consumers. The registers only follow the
// combinational result; reset clears them but never touches sum/co.
module csa
  import csa_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co,
  output logic [N-1:0] sum_q,
  output logic         co_q
);

  logic [N-1:0] sum_d;
  logic         co_d;

  csa_core #(.W(N)) u_core (
    .a_i   (a),
    .b_i   (b),
    .ci_i  (ci),
    .sum_o (sum_d),
    .co_o  (co_d)
  );

  // Combinational outputs come straight from the adder tree.
  always_comb begin
    sum = sum_d;
    co  = co_d;
  end

  // Capture the settled result each edge; reset discards the value in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end

endmodule

// File: tb/tb_csa.sv
// Directed and swept checks of the csa adder at widths 4, 1, 5 and 8.
module tb_csa;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0] a4, b4, sum4, sum4_q;
  logic       ci4, co4, co4_q;

  logic [0:0] a1, b1, sum1, sum1_q;
  logic       ci1, co1, co1_q;

  logic [4:0] a5, b5, sum5, sum5_q;
  logic       ci5, co5, co5_q;

  logic [7:0] a8, b8, sum8, sum8_q;
  logic       ci8, co8, co8_q;

  int checks;
  int errors;

  csa #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset), .a(a4), .b(b4), .ci(ci4),
    .sum(sum4), .co(co4), .sum_q(sum4_q), .co_q(co4_q)
  );

  csa #(.N(1)) u_dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .ci(ci1),
    .sum(sum1), .co(co1), .sum_q(sum1_q), .co_q(co1_q)
  );

  csa #(.N(5)) u_dut5 (
    .clk(clk), .reset(reset), .a(a5), .b(b5), .ci(ci5),
    .sum(sum5), .co(co5), .sum_q(sum5_q), .co_q(co5_q)
  );

  csa #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .ci(ci8),
    .sum(sum8), .co(co8), .sum_q(sum8_q), .co_q(co8_q)
  );

  // ---------------- driver tasks ----------------
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4  = a;
    b4  = b;
    ci4 = c;
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive4(4'd9, 4'd9, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sum4_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_sum_q: got %0d expected 0", sum4_q);
    end
    checks++;
    if (co4_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_co_q: got %0d expected 0", co4_q);
    end
    checks++;
    if (sum4 !== 4'd2) begin
      errors++;
      $display("FAIL reset_comb_sum: got %0d expected 2", sum4);
    end
    checks++;
    if (co4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb_co: got %0d expected 1", co4);
    end
  endtask

  task automatic test_boundary();
    logic [3:0] ta [5];
    logic [3:0] tb [5];
    logic       tc [5];
    logic [3:0] es [5];
    logic       ec [5];
    // boundary vectors, then carry across the select boundary
    ta = '{4'd15, 4'd0, 4'd8, 4'd3, 4'd7};
    tb = '{4'd15, 4'd0, 4'd8, 4'd0, 4'd8};
    tc = '{1'b1,  1'b0, 1'b0, 1'b1, 1'b1};
    es = '{4'd15, 4'd0, 4'd0, 4'd4, 4'd0};
    ec = '{1'b1,  1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive4(ta[i], tb[i], tc[i]);
      #5;
      checks++;
      if (sum4 !== es[i] || co4 !== ec[i]) begin
        errors++;
        $display("FAIL boundary_%0d: a=%0d b=%0d ci=%0d got co=%0d sum=%0d expected co=%0d sum=%0d",
                 i, ta[i], tb[i], tc[i], co4, sum4, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] exp;
    int n_vec;
    int n_bad;
    n_vec = 0;
    n_bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          drive4(4'(ia), 4'(ib), 1'(ic));
          #5;
          exp = 5'(ia) + 5'(ib) + 5'(ic);
          n_vec++;
          checks++;
          if ({co4, sum4} !== exp) begin
            errors++;
            n_bad++;
            if (n_bad <= 10)
              $display("FAIL exhaustive4: a=%0d b=%0d ci=%0d got %0d expected %0d",
                       ia, ib, ic, {co4, sum4}, exp);
          end
        end
      end
    end
    checks++;
    if (n_vec < 1) begin
      errors++;
      $display("FAIL exhaustive4_count: got %0d vectors expected at least 1", n_vec);
    end
  endtask

  task automatic test_latency();
    // release reset with 5+6 presented
    @(negedge clk);
    reset = 1'b0;
    drive4(4'd5, 4'd6, 1'b0);
    #1;
    checks++;
    if (sum4_q !== 4'd0 || co4_q !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got co_q=%0d sum_q=%0d expected co_q=0 sum_q=0", co4_q, sum4_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum4_q !== 4'd11 || co4_q !== 1'b0) begin
      errors++;
      $display("FAIL latency_first: got co_q=%0d sum_q=%0d expected co_q=0 sum_q=11", co4_q, sum4_q);
    end
    @(negedge clk);
    drive4(4'd12, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (sum4_q !== 4'd0 || co4_q !== 1'b1) begin
      errors++;
      $display("FAIL latency_second: got co_q=%0d sum_q=%0d expected co_q=1 sum_q=0", co4_q, sum4_q);
    end
  endtask

  task automatic test_reset_mid();
    // a result in flight is discarded by reset
    @(negedge clk);
    drive4(4'd15, 4'd15, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sum4_q !== 4'd0 || co4_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got co_q=%0d sum_q=%0d expected co_q=0 sum_q=0", co4_q, sum4_q);
    end
    @(negedge clk);
    reset = 1'b0;
    drive4(4'd2, 4'd3, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (sum4_q !== 4'd6 || co4_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got co_q=%0d sum_q=%0d expected co_q=0 sum_q=6", co4_q, sum4_q);
    end
  endtask

  task automatic test_width_sweep();
    logic [1:0] e1;
    logic [5:0] e5;
    logic [8:0] e8;
    int bad1, bad5, bad8;
    bad1 = 0;
    bad5 = 0;
    bad8 = 0;
    for (int i = 0; i < 1000; i++) begin
      a1  = 1'($urandom_range(0, 1));
      b1  = 1'($urandom_range(0, 1));
      ci1 = 1'($urandom_range(0, 1));
      a5  = 5'($urandom_range(0, 31));
      b5  = 5'($urandom_range(0, 31));
      ci5 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
      ci8 = 1'($urandom_range(0, 1));
      #2;
      e1 = {1'b0, a1} + {1'b0, b1} + 2'(ci1);
      e5 = {1'b0, a5} + {1'b0, b5} + 6'(ci5);
      e8 = {1'b0, a8} + {1'b0, b8} + 9'(ci8);
      checks++;
      if ({co1, sum1} !== e1) begin
        errors++;
        bad1++;
        if (bad1 <= 5)
          $display("FAIL sweep_n1: a=%0d b=%0d ci=%0d got %0d expected %0d", a1, b1, ci1, {co1, sum1}, e1);
      end
      checks++;
      if ({co5, sum5} !== e5) begin
        errors++;
        bad5++;
        if (bad5 <= 5)
          $display("FAIL sweep_n5: a=%0d b=%0d ci=%0d got %0d expected %0d", a5, b5, ci5, {co5, sum5}, e5);
      end
      checks++;
      if ({co8, sum8} !== e8) begin
        errors++;
        bad8++;
        if (bad8 <= 5)
          $display("FAIL sweep_n8: a=%0d b=%0d ci=%0d got %0d expected %0d", a8, b8, ci8, {co8, sum8}, e8);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and final report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive4(4'd0, 4'd0, 1'b0);
    a1 = '0; b1 = '0; ci1 = 1'b0;
    a5 = '0; b5 = '0; ci5 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;

    test_reset();
    test_latency();
    test_reset_mid();
    test_boundary();
    test_exhaustive();
    test_width_sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
